// File: rtl/fp_addsub_sched.sv
// fp_addsub_sched
// Shares one fixed-latency pipelined floating-point adder among NREQ
// requesters. A round-robin arbiter issues at most one operation per cycle.
// Subtraction is folded into the adder by flipping the sign bit of B.
// A tag pipeline carries the requester index alongside the adder so that
// each result returns to the requester that issued it. A requester is busy
// from its handshake until its response, so it has at most one op in flight.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req_valid[i]    requester i presents an operation
//   i_req_sub[i]      1 = A-B, 0 = A+B
//   i_req_a/i_req_b   operands, requester i in slice [i*W +: W]
//   o_req_ready[i]    combinational grant; handshake = valid & ready
//   o_add_valid       issue strobe to the shared adder (registered)
//   o_add_a/o_add_b   adder operands, B sign already adjusted
//   i_add_result      adder output, valid ADD_LAT cycles after o_add_valid
//   o_rsp_valid       one-hot owner of o_rsp_data (registered)
//   o_rsp_data        shared result bus, holds when no response
//   o_idle            registered "no operation in flight"
module fp_addsub_sched #(
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 3,
    parameter int W       = 27
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [NREQ-1:0]   i_req_sub,
    input  logic [NREQ*W-1:0] i_req_a,
    input  logic [NREQ*W-1:0] i_req_b,
    output logic [NREQ-1:0]   o_req_ready,
    output logic              o_add_valid,
    output logic [W-1:0]      o_add_a,
    output logic [W-1:0]      o_add_b,
    input  logic [W-1:0]      i_add_result,
    output logic [NREQ-1:0]   o_rsp_valid,
    output logic [W-1:0]      o_rsp_data,
    output logic              o_idle
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]   r_ptr;
    logic [NREQ-1:0] r_busy;
    logic            r_add_valid;
    logic [W-1:0]    r_add_a;
    logic [W-1:0]    r_add_b;
    logic [NREQ-1:0] r_rsp_valid;
    logic [W-1:0]    r_rsp_data;
    logic            r_idle;

    // Stage 0 lines up with o_add_valid; stage ADD_LAT lines up with
    // i_add_result.
    logic [ADD_LAT:0] r_vld_pipe;
    logic [IW-1:0]    r_idx_pipe [ADD_LAT:0];

    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_grant;
    logic            w_gnt_any;
    logic [IW-1:0]   w_gidx;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic [W-1:0]    w_adj_b;
    logic [IW-1:0]   w_ptr_nxt;
    logic [NREQ-1:0] w_retire;

    assign w_elig = i_req_valid & ~r_busy;

    // Round-robin scan starting at r_ptr; first eligible index wins.
    always_comb begin
        int j;
        j         = 0;
        w_grant   = '0;
        w_gnt_any = 1'b0;
        w_gidx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!w_gnt_any && w_elig[j]) begin
                w_gnt_any = 1'b1;
                w_gidx    = IW'(j);
            end
        end
        if (w_gnt_any) w_grant[w_gidx] = 1'b1;
    end

    assign w_sel_a   = i_req_a[w_gidx*W +: W];
    assign w_sel_b   = i_req_b[w_gidx*W +: W];
    // Pure sign-bit flip: zeros, infinities and NaNs only change sign.
    assign w_adj_b   = i_req_sub[w_gidx] ? {~w_sel_b[W-1], w_sel_b[W-2:0]} : w_sel_b;
    assign w_ptr_nxt = (w_gidx == IW'(NREQ-1)) ? '0 : w_gidx + 1'b1;

    always_comb begin
        w_retire = '0;
        if (r_vld_pipe[ADD_LAT]) w_retire[r_idx_pipe[ADD_LAT]] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_busy      <= '0;
            r_vld_pipe  <= '0;
            r_add_valid <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_idle      <= 1'b1;
        end else begin
            // Retirement and grant never hit the same index: a busy
            // requester is not eligible.
            r_busy      <= (r_busy & ~w_retire) | w_grant;
            r_vld_pipe  <= {r_vld_pipe[ADD_LAT-1:0], w_gnt_any};
            r_add_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_ptr   <= w_ptr_nxt;
                r_add_a <= w_sel_a;
                r_add_b <= w_adj_b;
            end
            r_rsp_valid <= w_retire;
            if (|w_retire) r_rsp_data <= i_add_result;
            r_idle      <= ~|r_busy;
        end
    end

    // Index pipe needs no reset: its entries are qualified by r_vld_pipe.
    always_ff @(posedge i_clk) begin
        r_idx_pipe[0] <= w_gidx;
        for (int k = 1; k <= ADD_LAT; k++) r_idx_pipe[k] <= r_idx_pipe[k-1];
    end

    assign o_req_ready = w_grant;
    assign o_add_valid = r_add_valid;
    assign o_add_a     = r_add_a;
    assign o_add_b     = r_add_b;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_idle      = r_idle;
endmodule

// File: tb/tb_fp_addsub_sched.sv
// Bench for fp_addsub_sched: an adder model behind the DUT, a schedule-table
// reference model, and directed plus randomized requester traffic.
module tb_fp_addsub_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 3;
    localparam int W    = 27;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid, req_sub;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_ready;
    logic              add_valid;
    logic [W-1:0]      add_a, add_b, add_result;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              idle;

    fp_addsub_sched #(.NREQ(NREQ), .ADD_LAT(LAT), .W(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_sub(req_sub),
        .i_req_a(req_a), .i_req_b(req_b), .o_req_ready(req_ready),
        .o_add_valid(add_valid), .o_add_a(add_a), .o_add_b(add_b),
        .i_add_result(add_result), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .o_idle(idle)
    );

    always #5 clk = ~clk;

    // Floating-point add through real arithmetic (result truncated).
    function automatic real to_r(input logic [W-1:0] x);
        logic [63:0] bits;
        if (x[25:18] == 8'd0) return 0.0;
        bits = {x[26], 11'(x[25:18]) + 11'd896, x[17:0], 34'd0};
        return $bitstoreal(bits);
    endfunction

    function automatic logic [W-1:0] from_r(input real r);
        logic [63:0] bits;
        logic [10:0] e;
        bits = $realtobits(r);
        e    = bits[62:52];
        if (e == 11'd0) return '0;
        return {bits[63], 8'(e - 11'd896), bits[51:34]};
    endfunction

    function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
        return from_r(to_r(a) + to_r(b));
    endfunction

    function automatic logic [W-1:0] rand_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 18'($urandom)};
    endfunction

    // Shared adder model: result appears LAT cycles after add_valid,
    // garbage otherwise so misaligned capture is visible.
    logic [W-1:0] apipe [LAT];
    initial for (int k = 0; k < LAT; k++) apipe[k] = '0;
    always @(posedge clk) begin
        apipe[0] <= (add_valid === 1'b1) ? fadd(add_a, add_b) : W'($urandom);
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
    assign add_result = apipe[LAT-1];

    // Reference model state.
    int            ncmp = 0, nfail = 0, cyc = 0;
    int            m_ptr;
    logic [NREQ-1:0] m_busy, m_rv;
    logic          m_av, m_idle;
    logic [W-1:0]  m_aa, m_ab, m_rd;
    logic          sch_v [16];
    int            sch_i [16];
    logic [W-1:0]  sch_d [16];
    logic          hold  [NREQ];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_busy = '0; m_rv = '0; m_av = 1'b0; m_idle = 1'b1;
        m_aa = '0; m_ab = '0; m_rd = '0;
        for (int k = 0; k < 16; k++) sch_v[k] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub);
        req_valid[i] = 1'b1; req_sub[i] = sub;
        req_a[i*W +: W] = a; req_b[i*W +: W] = b;
    endtask

    // One clock: check outputs, advance model across the edge, then let the
    // requesters react after the edge.
    task automatic cycle();
        logic [NREQ-1:0] eg;
        logic [W-1:0]    a, b;
        int              gi, j, s, t;
        #1;
        eg = '0; gi = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (eg == '0 && req_valid[j] && !m_busy[j]) begin eg[j] = 1'b1; gi = j; end
        end
        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("add_valid", 32'(add_valid), 32'(m_av));
        chk("add_a",     32'(add_a),     32'(m_aa));
        chk("add_b",     32'(add_b),     32'(m_ab));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rsp_data",  32'(rsp_data),  32'(m_rd));
        chk("idle",      32'(idle),      32'(m_idle));
        if (rst) begin
            model_reset();
            eg = '0;
        end else begin
            m_idle = (m_busy == '0);
            s = (cyc + 1) % 16;
            if (sch_v[s]) begin
                m_rv = '0; m_rv[sch_i[s]] = 1'b1; m_rd = sch_d[s];
                m_busy[sch_i[s]] = 1'b0; sch_v[s] = 1'b0;
            end else m_rv = '0;
            m_av = (eg != '0);
            if (eg != '0) begin
                a = req_a[gi*W +: W]; b = req_b[gi*W +: W];
                if (req_sub[gi]) b[W-1] = ~b[W-1];
                m_aa = a; m_ab = b; m_busy[gi] = 1'b1; m_ptr = (gi + 1) % NREQ;
                t = (cyc + 2 + LAT) % 16;
                sch_v[t] = 1'b1; sch_i[t] = gi; sch_d[t] = fadd(a, b);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (eg != '0) begin
            if (hold[gi]) set_req(gi, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
            else req_valid[gi] = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < NREQ; k++) hold[k] = 1'b0;
        run(n);
    endtask

    task automatic do_reset();
        rst = 1'b1; cycle(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_sub = '0; req_a = '0; req_b = '0;
        for (int k = 0; k < NREQ; k++) hold[k] = 1'b0;
        model_reset();
        @(posedge clk); @(negedge clk);
        cycle();                       // reset state check
        rst = 1'b0;

        // Single add: 1.0 + 1.0
        set_req(0, 27'h1FC0000, 27'h1FC0000, 1'b0);
        run(8);
        // Subtract, then subtract of -0 (sign flips to +0)
        set_req(2, 27'h2000000, 27'h1FC0000, 1'b1);
        run(8);
        set_req(2, 27'h1FC0000, 27'h4000000, 1'b1);
        run(8);

        // Round-robin from reset: all four at once
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, rand_fp(), rand_fp(), 1'(i & 1));
        run(10);
        // Continuous traffic from all requesters
        for (int i = 0; i < NREQ; i++) begin
            hold[i] = 1'b1; set_req(i, rand_fp(), rand_fp(), 1'b0);
        end
        run(20);
        drain(10);

        // Back-to-back on req1 with occasional others
        hold[1] = 1'b1; set_req(1, rand_fp(), rand_fp(), 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (k % 4 == 2 && !req_valid[0]) set_req(0, rand_fp(), rand_fp(), 1'b0);
            if (k % 6 == 3 && !req_valid[2]) set_req(2, rand_fp(), rand_fp(), 1'b1);
            cycle();
        end
        drain(10);

        // Fairness: req0 and req3 continuously valid from ptr=0
        do_reset();
        hold[0] = 1'b1; hold[3] = 1'b1;
        set_req(0, rand_fp(), rand_fp(), 1'b0);
        set_req(3, rand_fp(), rand_fp(), 1'b1);
        run(20);
        drain(10);

        // Reset with three ops in flight; adder results afterwards ignored
        for (int i = 0; i < 3; i++) set_req(i, rand_fp(), rand_fp(), 1'b0);
        run(3);
        run(2);
        do_reset();
        run(8);
        set_req(1, rand_fp(), rand_fp(), 1'b0);
        set_req(3, rand_fp(), rand_fp(), 1'b0);
        run(10);

        // Randomized traffic with rare resets
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1; cycle(); rst = 1'b0;
            end else cycle();
        end
        drain(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
